lut_loader: RTL and testbench
=============================

LUT_LOADER -- requirements
Module: lut_loader

Interface
REQ-001 Parameter DEPTH, 32, number of branch-target entries.
REQ-002 Parameter AW, 5, index width (log2 DEPTH).
REQ-003 Parameter TW, 10, target width.
REQ-004 Parameter DEFAULT_TARGET, 10'h001, value read from any unprogrammed entry.
REQ-005 Clk  input  1  sole clock; all state updates on rising edge.
REQ-006 Reset  input  1  asynchronous, active-low reset.
REQ-007 WrValid  input  1  write request present.
REQ-008 WrReady  output  1  loader can accept a write this cycle.
REQ-009 WrAddr  input  AW  entry index to program.
REQ-010 WrTarget  input  TW  target value to store.
REQ-011 ClrReq  input  1  single-cycle request to restore all entries to default.
REQ-012 Busy  output  1  clear sweep in progress.
REQ-013 ClrDone  output  1  one-cycle pulse when clear sweep completes.
REQ-014 Addr  input  AW  read index from fetch logic.
REQ-015 Target  output  TW  stored target for Addr.
REQ-016 Hit  output  1  entry at Addr has been programmed since last reset/clear.
REQ-017 Count  output  AW+1  number of programmed entries, 0..DEPTH.

Function
REQ-018 Storage SHALL hold DEPTH entries of TW bits, each with one programmed bit.
REQ-019 Read path SHALL be combinational: Target = entry[Addr], Hit = programmed[Addr]; unprogrammed entries SHALL read DEFAULT_TARGET.
REQ-020 FSM states: IDLE, CLEAR, DONE.
REQ-021 WrReady SHALL be 1 only in IDLE with ClrReq low.
REQ-022 Write transfer SHALL occur on a rising edge with WrValid and WrReady both 1; entry and programmed bit update at that edge, visible on Target/Hit the following cycle.
REQ-023 Read of an address in the same cycle as its write transfer SHALL return the old value.
REQ-024 Count SHALL increment by 1 on a transfer to an unprogrammed entry; a transfer to a programmed entry SHALL overwrite the target and leave Count unchanged.
REQ-025 WrValid while WrReady is 0 SHALL have no effect; the requester holds WrAddr/WrTarget until transfer.
REQ-026 IDLE -> CLEAR on ClrReq=1; ClrReq wins over a simultaneous WrValid (no write occurs).
REQ-027 CLEAR SHALL sweep index 0..DEPTH-1, one entry per cycle, writing DEFAULT_TARGET and clearing the programmed bit; exactly DEPTH cycles.
REQ-028 Count SHALL read 0 from the cycle after the last sweep write.
REQ-029 CLEAR -> DONE after index DEPTH-1; DONE -> IDLE after one cycle; ClrDone=1 only in DONE.
REQ-030 Busy SHALL be 1 in CLEAR and DONE, 0 in IDLE.
REQ-031 ClrReq during CLEAR or DONE SHALL be ignored.
REQ-032 Sweep index counter SHALL be AW bits and not wrap into a second pass.

Reset
REQ-033 Reset low SHALL immediately force state IDLE, all entries DEFAULT_TARGET, all programmed bits 0, Count 0, sweep index 0.
REQ-034 Reset-time outputs: WrReady 1 (if ClrReq low), Busy 0, ClrDone 0, Hit 0, Target DEFAULT_TARGET.
REQ-035 Reset asserted mid-CLEAR SHALL abort the sweep with no ClrDone pulse.

Structure
REQ-036 Shared package lut_pkg SHALL hold AW, TW, DEPTH, DEFAULT_TARGET and the FSM state enum.
REQ-037 Storage plus programmed bits SHALL be one sub-module, lut_table (one write port, one combinational read port); FSM, handshake and Count in lut_loader.

Verification
REQ-038 After reset, read all 32 Addr -> Target 10'h001, Hit 0, Count 0, WrReady 1.
REQ-039 Write Addr 5'b00110 <- 10'h021 -> same cycle Target 10'h001; next cycle Target 10'h021, Hit 1, Count 1.
REQ-040 Rewrite 5'b00110 <- 10'h06C -> Target 10'h06C, Count stays 1.
REQ-041 Program 11 entries, pulse ClrReq with WrValid high -> no write, Busy 1 for 33 cycles, ClrDone at cycle 33, then all Target 10'h001, Count 0.
REQ-042 Assert Reset at sweep index 10 -> immediate IDLE, no ClrDone, all entries default, Count 0.
REQ-043 Program all 32 entries -> Count 6'd32; WrValid held during CLEAR -> WrReady 0, no transfer until IDLE.

Source files
------------

// File: rtl/lut_pkg.sv
// Shared constants and FSM state encoding for the branch-target LUT loader.
package lut_pkg;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int TW    = 10;
  localparam logic [TW-1:0] DEFAULT_TARGET = 10'h001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/lut_table.sv
// Branch-target storage with per-entry programmed bits.
// Provides one write port and one combinational read port.
module lut_table #(
  parameter int DEPTH = lut_pkg::DEPTH,
  parameter int AW    = lut_pkg::AW,
  parameter int TW    = lut_pkg::TW,
  parameter logic [TW-1:0] DEFAULT_TARGET = lut_pkg::DEFAULT_TARGET
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [TW-1:0]    i_wdata,
  input  logic             i_wprog,
  input  logic [AW-1:0]    i_raddr,
  output logic [TW-1:0]    o_rdata,
  output logic             o_rhit,
  output logic [DEPTH-1:0] o_prog
);

  logic [TW-1:0]    r_entry [DEPTH];
  logic [DEPTH-1:0] r_prog;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= DEFAULT_TARGET;
      end
      r_prog <= '0;
    end else if (i_we) begin
      r_entry[i_waddr] <= i_wdata;
      r_prog[i_waddr]  <= i_wprog;
    end
  end

  // Unprogrammed entries always read as the default target.
  assign o_rhit  = r_prog[i_raddr];
  assign o_rdata = r_prog[i_raddr] ? r_entry[i_raddr] : DEFAULT_TARGET;
  assign o_prog  = r_prog;

endmodule

// File: rtl/lut_loader.sv
// Branch-target LUT loader: write handshake, programmed-entry count and
// a clear sweep that restores every entry to the default target.
module lut_loader #(
  parameter int DEPTH = lut_pkg::DEPTH,
  parameter int AW    = lut_pkg::AW,
  parameter int TW    = lut_pkg::TW,
  parameter logic [TW-1:0] DEFAULT_TARGET = lut_pkg::DEFAULT_TARGET
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          WrValid,
  output logic          WrReady,
  input  logic [AW-1:0] WrAddr,
  input  logic [TW-1:0] WrTarget,
  input  logic          ClrReq,
  output logic          Busy,
  output logic          ClrDone,
  input  logic [AW-1:0] Addr,
  output logic [TW-1:0] Target,
  output logic          Hit,
  output logic [AW:0]   Count
);

  import lut_pkg::state_e;
  import lut_pkg::ST_IDLE;
  import lut_pkg::ST_CLEAR;
  import lut_pkg::ST_DONE;

  // state | meaning
  // IDLE  | accepting writes, waiting for ClrReq
  // CLEAR | sweeping index 0..DEPTH-1 back to default, one per cycle
  // DONE  | one-cycle completion pulse, then back to IDLE
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_e           r_state;
  logic [AW-1:0]    r_idx;
  logic [AW:0]      r_count;
  logic             r_busy;
  logic             r_clr_done;

  logic             w_xfer;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [TW-1:0]    w_wdata;
  logic             w_wprog;
  logic [DEPTH-1:0] w_prog;

  assign WrReady = (r_state == ST_IDLE) && !ClrReq;
  assign w_xfer  = WrValid && WrReady;

  always_comb begin
    w_we    = w_xfer;
    w_waddr = WrAddr;
    w_wdata = WrTarget;
    w_wprog = 1'b1;
    if (r_state == ST_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_idx;
      w_wdata = DEFAULT_TARGET;
      w_wprog = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_clr_done <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ClrReq) begin
            r_state <= ST_CLEAR;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end else if (w_xfer && !w_prog[WrAddr]) begin
            r_count <= r_count + (AW+1)'(1);
          end
        end
        ST_CLEAR: begin
          if (r_idx == LAST_IDX) begin
            r_state    <= ST_DONE;
            r_idx      <= '0;
            r_count    <= '0;
            r_clr_done <= 1'b1;
          end else begin
            r_idx <= r_idx + AW'(1);
          end
        end
        ST_DONE: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_clr_done <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_clr_done <= 1'b0;
        end
      endcase
    end
  end

  assign Busy    = r_busy;
  assign ClrDone = r_clr_done;
  assign Count   = r_count;

  lut_table #(
    .DEPTH          (DEPTH),
    .AW             (AW),
    .TW             (TW),
    .DEFAULT_TARGET (DEFAULT_TARGET)
  ) u_table (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_wprog (w_wprog),
    .i_raddr (Addr),
    .o_rdata (Target),
    .o_rhit  (Hit),
    .o_prog  (w_prog)
  );

endmodule

// File: tb/tb_lut_loader.sv
// Directed-vector bench for lut_loader: table-driven write/read vectors plus
// hand-written clear-sweep, reset-abort and held-write sequences.
module tb_lut_loader;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       WrValid = 1'b0;
  logic       WrReady;
  logic [4:0] WrAddr = '0;
  logic [9:0] WrTarget = '0;
  logic       ClrReq = 1'b0;
  logic       Busy;
  logic       ClrDone;
  logic [4:0] Addr = '0;
  logic [9:0] Target;
  logic       Hit;
  logic [5:0] Count;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 Clk = ~Clk;

  lut_loader dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .WrValid  (WrValid),
    .WrReady  (WrReady),
    .WrAddr   (WrAddr),
    .WrTarget (WrTarget),
    .ClrReq   (ClrReq),
    .Busy     (Busy),
    .ClrDone  (ClrDone),
    .Addr     (Addr),
    .Target   (Target),
    .Hit      (Hit),
    .Count    (Count)
  );

  typedef struct {
    logic       wv;
    logic [4:0] wa;
    logic [9:0] wt;
    logic [4:0] ra;
    logic [9:0] e_tgt;
    logic       e_hit;
    logic [5:0] e_cnt;
    logic       e_rdy;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b0;
    #2;
    Reset = 1'b1;
    tick();
  endtask

  task automatic wr(input logic [4:0] a, input logic [9:0] t);
    WrValid  = 1'b1;
    WrAddr   = a;
    WrTarget = t;
    tick();
    WrValid  = 1'b0;
  endtask

  task automatic check_all_default(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      Addr = 5'(i);
      #0.1;
      if (Target !== 10'h001 || Hit !== 1'b0) bad++;
    end
    chk(name, bad, 0);
  endtask

  // Counts cycles with Busy high from the cycle after ClrReq is taken.
  task automatic run_clear(input string name, output int busy_cyc, output int done_at);
    busy_cyc = 0;
    done_at  = -1;
    while (Busy === 1'b1 && busy_cyc < 100) begin
      busy_cyc++;
      if (ClrDone === 1'b1) begin
        done_at = busy_cyc;
        chk({name, "_count_in_done"}, Count, 0);
      end
      if (WrReady !== 1'b0) chk({name, "_ready_busy"}, WrReady, 0);
      tick();
    end
    chk({name, "_busy_cycles"}, busy_cyc, 33);
    chk({name, "_clrdone_cycle"}, done_at, 33);
  endtask

  initial begin
    int bc, da, seen_done;

    vecs[0]  = '{1'b0, 5'd0,  10'h000, 5'd6,  10'h001, 1'b0, 6'd0, 1'b1};
    vecs[1]  = '{1'b1, 5'd6,  10'h021, 5'd6,  10'h001, 1'b0, 6'd0, 1'b1};
    vecs[2]  = '{1'b0, 5'd0,  10'h000, 5'd6,  10'h021, 1'b1, 6'd1, 1'b1};
    vecs[3]  = '{1'b1, 5'd6,  10'h06C, 5'd6,  10'h021, 1'b1, 6'd1, 1'b1};
    vecs[4]  = '{1'b0, 5'd0,  10'h000, 5'd6,  10'h06C, 1'b1, 6'd1, 1'b1};
    vecs[5]  = '{1'b1, 5'd31, 10'h3FF, 5'd31, 10'h001, 1'b0, 6'd1, 1'b1};
    vecs[6]  = '{1'b0, 5'd0,  10'h000, 5'd31, 10'h3FF, 1'b1, 6'd2, 1'b1};
    vecs[7]  = '{1'b1, 5'd0,  10'h000, 5'd0,  10'h001, 1'b0, 6'd2, 1'b1};
    vecs[8]  = '{1'b0, 5'd0,  10'h000, 5'd0,  10'h000, 1'b1, 6'd3, 1'b1};
    vecs[9]  = '{1'b0, 5'd0,  10'h000, 5'd5,  10'h001, 1'b0, 6'd3, 1'b1};
    vecs[10] = '{1'b0, 5'd0,  10'h000, 5'd6,  10'h06C, 1'b1, 6'd3, 1'b1};

    // Reset state
    #3;
    chk("rst_busy", Busy, 0);
    chk("rst_clrdone", ClrDone, 0);
    chk("rst_ready", WrReady, 1);
    Reset = 1'b1;
    tick();
    check_all_default("rst_all_default");
    chk("rst_count", Count, 0);

    // Table-driven writes, overwrites and same-cycle reads
    for (int v = 0; v < 11; v++) begin
      WrValid  = vecs[v].wv;
      WrAddr   = vecs[v].wa;
      WrTarget = vecs[v].wt;
      Addr     = vecs[v].ra;
      #1;
      chk($sformatf("vec%0d_target", v), Target, vecs[v].e_tgt);
      chk($sformatf("vec%0d_hit", v), Hit, vecs[v].e_hit);
      chk($sformatf("vec%0d_count", v), Count, vecs[v].e_cnt);
      chk($sformatf("vec%0d_ready", v), WrReady, vecs[v].e_rdy);
      tick();
    end
    WrValid = 1'b0;

    // Clear with simultaneous write request: ClrReq wins
    do_reset();
    for (int i = 0; i < 11; i++) wr(5'(2 * i), 10'h100 + 10'(i));
    chk("clr_pre_count", Count, 11);
    ClrReq = 1'b1; WrValid = 1'b1; WrAddr = 5'd1; WrTarget = 10'h2AA;
    #1;
    chk("clr_ready_low", WrReady, 0);
    tick();
    ClrReq = 1'b0;
    run_clear("clr", bc, da);
    WrValid = 1'b0;
    chk("clr_idle_busy", Busy, 0);
    chk("clr_idle_count", Count, 0);
    check_all_default("clr_all_default");

    // Reset mid-sweep at index 10
    do_reset();
    wr(5'd3, 10'h0F0);
    wr(5'd20, 10'h1E1);
    ClrReq = 1'b1;
    tick();
    ClrReq = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #1;
    Reset = 1'b0;
    #1;
    chk("abort_busy", Busy, 0);
    chk("abort_ready", WrReady, 1);
    chk("abort_count", Count, 0);
    @(negedge Clk);
    Reset = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ClrDone === 1'b1) seen_done = 1;
    end
    chk("abort_no_clrdone", seen_done, 0);
    check_all_default("abort_all_default");

    // Full table, then a write held through the whole sweep
    do_reset();
    for (int i = 0; i < 32; i++) wr(5'(i), 10'h040 + 10'(i));
    chk("full_count", Count, 32);
    Addr = 5'd31;
    #1;
    chk("full_target31", Target, 10'h05F);
    ClrReq = 1'b1;
    tick();
    ClrReq = 1'b0; WrValid = 1'b1; WrAddr = 5'd7; WrTarget = 10'h0AB; Addr = 5'd7;
    run_clear("held", bc, da);
    chk("held_idle_ready", WrReady, 1);
    chk("held_idle_count", Count, 0);
    chk("held_pre_target", Target, 10'h001);
    tick();
    WrValid = 1'b0;
    #1;
    chk("held_post_target", Target, 10'h0AB);
    chk("held_post_hit", Hit, 1);
    chk("held_post_count", Count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
